// File: rtl/median5x5_pkg.sv
// Shared constants, types and helpers for the 5x5 bit-serial median filter.
package median_pkg;

    localparam int DATA_W   = 8;
    localparam int KERNEL_N = 25;
    localparam int RANK     = (KERNEL_N + 1) / 2;
    localparam int LATENCY  = DATA_W;
    localparam int CNT_W    = $clog2(KERNEL_N + 1);
    localparam int KERNEL_W = KERNEL_N * DATA_W;

    typedef logic [KERNEL_W-1:0] kernel_t;
    typedef logic [DATA_W-1:0]   pixel_t;

    // Control/sideband bits that ride alongside each kernel through the pipe
    typedef struct packed {
        logic valid;
        logic hs;
        logic vs;
    } side_t;

    // Element i of a packed kernel bus
    function automatic pixel_t kernel_elem(input kernel_t k, input int i);
        return k[i*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/median5x5_if.sv
// Kernel input bundle and filtered-pixel output bundle of the median core.
interface median5x5_if;
    import median_pkg::*;

    kernel_t kernel_red;
    kernel_t kernel_green;
    kernel_t kernel_blue;
    logic    kernel_valid;
    logic    kernel_hs;
    logic    kernel_vs;

    pixel_t  med_red;
    pixel_t  med_green;
    pixel_t  med_blue;
    logic    med_valid;
    logic    med_hs;
    logic    med_vs;

    modport master (
        output kernel_red, kernel_green, kernel_blue,
        output kernel_valid, kernel_hs, kernel_vs,
        input  med_red, med_green, med_blue,
        input  med_valid, med_hs, med_vs
    );

    modport slave (
        input  kernel_red, kernel_green, kernel_blue,
        input  kernel_valid, kernel_hs, kernel_vs,
        output med_red, med_green, med_blue,
        output med_valid, med_hs, med_vs
    );

endinterface

// File: rtl/median5x5_bit_stage.sv
// One bit-plane of the radix-select median for a single channel.
// Decides median bit BIT by majority against RANK, then collapses the lower
// bits of every value on the losing side so later planes still count it on
// the correct side of the median.
module median_bit_stage
    import median_pkg::*;
#(
    parameter int BIT = DATA_W - 1
) (
    input  logic    clk,
    input  logic    rst,
    input  kernel_t vals_in,
    input  pixel_t  med_in,
    output kernel_t vals_out,
    output pixel_t  med_out
);

    logic [CNT_W-1:0] cnt;
    logic             m_bit;
    pixel_t           elem;
    kernel_t          vals_nxt;
    pixel_t           med_nxt;
    kernel_t          vals_p;
    pixel_t           med_p;

    // Popcount this bit plane, pick the median bit, rewrite the losers' lower bits
    always_comb begin
        cnt      = '0;
        elem     = '0;
        vals_nxt = vals_in;
        med_nxt  = med_in;
        for (int i = 0; i < KERNEL_N; i++) begin
            elem = kernel_elem(vals_in, i);
            cnt  = cnt + CNT_W'(elem[BIT]);
        end
        m_bit        = (cnt >= CNT_W'(RANK));
        med_nxt[BIT] = m_bit;
        for (int i = 0; i < KERNEL_N; i++) begin
            elem = kernel_elem(vals_in, i);
            if (elem[BIT] != m_bit) begin
                for (int j = 0; j < BIT; j++) begin
                    elem[j] = elem[BIT];
                end
            end
            vals_nxt[i*DATA_W +: DATA_W] = elem;
        end
    end

    // Stage boundary: working values and partial median
    always_ff @(posedge clk) begin
        if (rst) begin
            vals_p <= '0;
            med_p  <= '0;
        end else begin
            vals_p <= vals_nxt;
            med_p  <= med_nxt;
        end
    end

    assign vals_out = vals_p;
    assign med_out  = med_p;

endmodule

// File: rtl/median5x5.sv
// 5x5 per-channel median filter: DATA_W bit-serial stages per colour channel,
// one kernel accepted per clock, result LATENCY cycles later.
module median5x5
    import median_pkg::*;
(
    input logic       clk,
    input logic       rst,
    median5x5_if.slave bus
);

    localparam int N_CH = 3;

    kernel_t vals_chain  [N_CH][DATA_W];
    pixel_t  med_chain   [N_CH][DATA_W+1];
    kernel_t vals_unused [N_CH];
    side_t   side_p      [LATENCY];

    assign vals_chain[0][0] = bus.kernel_red;
    assign vals_chain[1][0] = bus.kernel_green;
    assign vals_chain[2][0] = bus.kernel_blue;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign med_chain[c][0] = '0;
        for (genvar s = 0; s < DATA_W; s++) begin : g_bit
            kernel_t vals_o;

            median_bit_stage #(
                .BIT(DATA_W - 1 - s)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .vals_in  (vals_chain[c][s]),
                .med_in   (med_chain[c][s]),
                .vals_out (vals_o),
                .med_out  (med_chain[c][s+1])
            );

            // The last plane's working values are not needed by anything
            if (s < DATA_W - 1) begin : g_fwd
                assign vals_chain[c][s+1] = vals_o;
            end else begin : g_last
                assign vals_unused[c] = vals_o;
            end
        end
    end

    // Delay valid and syncs by the same depth as the data pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                side_p[i] <= '0;
            end
        end else begin
            side_p[0] <= '{valid: bus.kernel_valid, hs: bus.kernel_hs, vs: bus.kernel_vs};
            for (int i = 1; i < LATENCY; i++) begin
                side_p[i] <= side_p[i-1];
            end
        end
    end

    assign bus.med_red   = med_chain[0][DATA_W];
    assign bus.med_green = med_chain[1][DATA_W];
    assign bus.med_blue  = med_chain[2][DATA_W];
    assign bus.med_valid = side_p[LATENCY-1].valid;
    assign bus.med_hs    = side_p[LATENCY-1].hs;
    assign bus.med_vs    = side_p[LATENCY-1].vs;

endmodule

// File: tb/tb_median5x5.sv
// Directed bench for median5x5: fixed kernels, a short randomized stream
// against a sort-based median, and reset behaviour.
module tb_median5x5;

    logic clk;
    logic rst;

    median5x5_if bus ();

    median5x5 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef logic [24:0][7:0] kern_t;

    kern_t ka, kb, kc, kz;

    localparam int NSTREAM = 24;
    logic [7:0] exp_r  [NSTREAM];
    logic [7:0] exp_g  [NSTREAM];
    logic [7:0] exp_b  [NSTREAM];
    logic       exp_v  [NSTREAM];
    logic       exp_hs [NSTREAM];
    logic       exp_vs [NSTREAM];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input kern_t r, input kern_t g, input kern_t b,
                         input logic v, input logic hs, input logic vs);
        bus.kernel_red   = r;
        bus.kernel_green = g;
        bus.kernel_blue  = b;
        bus.kernel_valid = v;
        bus.kernel_hs    = hs;
        bus.kernel_vs    = vs;
    endtask

    function automatic logic [7:0] sw_median(input kern_t k);
        logic [7:0] a [25];
        logic [7:0] t;
        for (int i = 0; i < 25; i++) a[i] = k[i];
        for (int i = 0; i < 24; i++)
            for (int j = 0; j < 24 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        return a[12];
    endfunction

    function automatic logic [7:0] pick();
        int sel;
        sel = $urandom_range(0, 5);
        if (sel == 0) return 8'h00;
        if (sel == 1) return 8'hFF;
        return 8'($urandom_range(0, 255));
    endfunction

    // One kernel with hs/vs set, expect it exactly 8 cycles later for one cycle
    task automatic run_kernel(input string tag, input kern_t r, input kern_t g, input kern_t b,
                              input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
        @(negedge clk);
        drive(r, g, b, 1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) drive(kz, kz, kz, 1'b0, 1'b0, 1'b0);
            if (k < 8) begin
                chk({tag, "/early_valid"}, 32'(bus.med_valid), 32'd0);
                chk({tag, "/early_hs"},    32'(bus.med_hs),    32'd0);
            end else begin
                chk({tag, "/valid"}, 32'(bus.med_valid), 32'd1);
                chk({tag, "/hs"},    32'(bus.med_hs),    32'd1);
                chk({tag, "/vs"},    32'(bus.med_vs),    32'd1);
                chk({tag, "/red"},   32'(bus.med_red),   32'(er));
                chk({tag, "/green"}, 32'(bus.med_green), 32'(eg));
                chk({tag, "/blue"},  32'(bus.med_blue),  32'(eb));
            end
        end
        @(negedge clk);
        chk({tag, "/one_cycle"}, 32'(bus.med_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        kz = '0;

        // Reset holds everything at zero even with a valid kernel presented
        for (int i = 0; i < 25; i++) ka[i] = 8'hAA;
        rst = 1'b1;
        drive(ka, ka, ka, 1'b1, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        chk("reset/red",   32'(bus.med_red),   32'd0);
        chk("reset/green", 32'(bus.med_green), 32'd0);
        chk("reset/blue",  32'(bus.med_blue),  32'd0);
        chk("reset/valid", 32'(bus.med_valid), 32'd0);
        chk("reset/hs",    32'(bus.med_hs),    32'd0);
        chk("reset/vs",    32'(bus.med_vs),    32'd0);
        drive(kz, kz, kz, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Uniform kernel
        for (int i = 0; i < 25; i++) ka[i] = 8'h5A;
        run_kernel("flat5a", ka, ka, ka, 8'h5A, 8'h5A, 8'h5A);

        // Ramps: 0..24, 24..0, 100..124
        for (int i = 0; i < 25; i++) begin
            ka[i] = 8'(i);
            kb[i] = 8'(24 - i);
            kc[i] = 8'(100 + i);
        end
        run_kernel("ramps", ka, kb, kc, 8'h0C, 8'h0C, 8'h70);

        // Extremes: 13xFF/12x00, 13x00/12xFF, impulse in a flat 0x80 field
        for (int i = 0; i < 25; i++) begin
            ka[i] = (i % 2 == 0) ? 8'hFF : 8'h00;
            kb[i] = (i % 2 == 0) ? 8'h00 : 8'hFF;
            kc[i] = (i == 7) ? 8'hFF : 8'h80;
        end
        run_kernel("extremes", ka, kb, kc, 8'hFF, 8'h00, 8'h80);

        // Back-to-back stream with valid gaps and sync pulses
        for (int c = 0; c < NSTREAM + 8; c++) begin
            @(negedge clk);
            if (c >= 8) begin
                chk("stream/valid", 32'(bus.med_valid), 32'(exp_v[c-8]));
                chk("stream/hs",    32'(bus.med_hs),    32'(exp_hs[c-8]));
                chk("stream/vs",    32'(bus.med_vs),    32'(exp_vs[c-8]));
                if (exp_v[c-8]) begin
                    chk("stream/red",   32'(bus.med_red),   32'(exp_r[c-8]));
                    chk("stream/green", 32'(bus.med_green), 32'(exp_g[c-8]));
                    chk("stream/blue",  32'(bus.med_blue),  32'(exp_b[c-8]));
                end
            end
            if (c < NSTREAM) begin
                for (int i = 0; i < 25; i++) begin
                    ka[i] = pick();
                    kb[i] = pick();
                    kc[i] = pick();
                end
                exp_v[c]  = ($urandom_range(0, 3) != 0);
                exp_hs[c] = 1'($urandom_range(0, 1));
                exp_vs[c] = ($urandom_range(0, 4) == 0);
                exp_r[c]  = sw_median(ka);
                exp_g[c]  = sw_median(kb);
                exp_b[c]  = sw_median(kc);
                drive(ka, kb, kc, exp_v[c], exp_hs[c], exp_vs[c]);
            end else begin
                drive(kz, kz, kz, 1'b0, 1'b0, 1'b0);
            end
        end
        repeat (2) @(negedge clk);

        // Three valid kernels then a one-cycle reset: none of them may emerge
        for (int i = 0; i < 25; i++) ka[i] = 8'h33;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            drive(ka, ka, ka, 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        drive(kz, kz, kz, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst/red",   32'(bus.med_red),   32'd0);
        chk("midrst/green", 32'(bus.med_green), 32'd0);
        chk("midrst/blue",  32'(bus.med_blue),  32'd0);
        chk("midrst/valid", 32'(bus.med_valid), 32'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("midrst/recover_valid", 32'(bus.med_valid), 32'd0);
            chk("midrst/recover_red",   32'(bus.med_red),   32'd0);
        end
        for (int i = 0; i < 25; i++) begin
            ka[i] = 8'(i * 10);
            kb[i] = 8'h44;
            kc[i] = (i < 13) ? 8'h10 : 8'hF0;
        end
        run_kernel("after_rst", ka, kb, kc, 8'h78, 8'h44, 8'h10);

        // Reset in the same cycle as a valid kernel drops that kernel
        for (int i = 0; i < 25; i++) ka[i] = 8'h77;
        @(negedge clk);
        drive(ka, ka, ka, 1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(kz, kz, kz, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("rst_same/valid", 32'(bus.med_valid), 32'd0);
            chk("rst_same/hs",    32'(bus.med_hs),    32'd0);
            chk("rst_same/red",   32'(bus.med_red),   32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
